// File: rtl/button_led_arbiter.sv
// -----------------------------------------------------------------------------
// button_led_arbiter
//
// Shares one LED between N_BTN push-buttons. Each raw button level is passed
// through a two-flop synchroniser and a consecutive-cycle debouncer. A rising
// debounced level is a press event that requests the LED. Simultaneous
// requests are resolved round-robin. The owner keeps the LED lit until it
// releases its button or, when enabled, its maximum hold time expires. A guard
// interval follows every release before the next grant is accepted.
//
// Ports:
//   clk      - system clock
//   rst      - asynchronous active-high reset
//   button   - raw asynchronous button levels, 1 = pressed
//   led      - LED drive, 1 = on
//   grant    - one-hot current owner, zero when nobody owns the LED
//   owner    - index of the current or most recent owner
//   denied   - one-cycle pulse when a press event is not granted
//   timeout  - one-cycle pulse when the owner is forcibly released
// -----------------------------------------------------------------------------
module button_led_arbiter #(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int GUARD_CYCLES    = 8,
    parameter int MAX_HOLD_CYCLES = 0,
    localparam int OW             = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] button,
    output logic             led,
    output logic [N_BTN-1:0] grant,
    output logic [OW-1:0]    owner,
    output logic             denied,
    output logic             timeout
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam int HW = (MAX_HOLD_CYCLES > 1) ? $clog2(MAX_HOLD_CYCLES) : 1;

    localparam logic [DW-1:0]    DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [GW-1:0]    GUARD_LAST = GW'(GUARD_CYCLES - 1);
    localparam logic [HW-1:0]    HOLD_LAST  = HW'((MAX_HOLD_CYCLES > 0) ? (MAX_HOLD_CYCLES - 1) : 0);
    localparam logic             HOLD_EN    = (MAX_HOLD_CYCLES != 0);
    localparam logic [N_BTN-1:0] ONE_HOT0   = N_BTN'(1);
    localparam logic [OW-1:0]    LAST_INIT  = OW'(N_BTN - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_OWNED = 2'd1;
    localparam logic [1:0] ST_GUARD = 2'd2;

    // Input conditioning state
    logic [N_BTN-1:0] s1_q, s1_d;
    logic [N_BTN-1:0] s2_q, s2_d;
    logic [N_BTN-1:0] deb_q, deb_d;
    logic [N_BTN-1:0] deb_prev_q, deb_prev_d;
    logic [DW-1:0]    cnt_q [N_BTN];
    logic [DW-1:0]    cnt_d [N_BTN];

    // Arbitration state
    logic [1:0]       state_q, state_d;
    logic             led_q, led_d;
    logic [N_BTN-1:0] grant_q, grant_d;
    logic [OW-1:0]    owner_q, owner_d;
    logic [OW-1:0]    last_q, last_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [GW-1:0]    guard_q, guard_d;
    logic             denied_q, denied_d;
    logic             timeout_q, timeout_d;

    // Combinational helpers
    logic [N_BTN-1:0] press_s;
    logic             win_found_s;
    logic [OW-1:0]    win_idx_s;
    logic [N_BTN-1:0] win_oh_s;

    // Debounce: a mismatch must persist DEBOUNCE_CYCLES edges before deb follows
    always_comb begin
        s1_d       = button;
        s2_d       = s1_q;
        deb_prev_d = deb_q;
        deb_d      = deb_q;
        for (int i = 0; i < N_BTN; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == DEB_LAST) begin
                    deb_d[i] = s2_q[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + DW'(1);
                end
            end else begin
                cnt_d[i] = '0;
            end
        end
    end

    // Synchroniser, debounced level and press-detect history registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q       <= '0;
            s2_q       <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_prev_d;
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Round-robin pick: scanning from last+1 upward; the loop runs backwards
    // so the final overwrite is the first pressing index in scan order.
    always_comb begin
        int             sum;
        logic [OW-1:0]  idx;
        press_s     = deb_q & ~deb_prev_q;
        win_found_s = |press_s;
        win_idx_s   = '0;
        sum         = 0;
        idx         = '0;
        for (int k = N_BTN; k >= 1; k--) begin
            sum       = int'(last_q) + k;
            idx       = OW'((sum >= N_BTN) ? (sum - N_BTN) : sum);
            win_idx_s = press_s[idx] ? idx : win_idx_s;
        end
        win_oh_s = ONE_HOT0 << win_idx_s;
    end

    // Ownership state machine; every output is computed here and registered
    always_comb begin
        state_d   = state_q;
        led_d     = led_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        last_d    = last_q;
        hold_d    = hold_q;
        guard_d   = guard_q;
        denied_d  = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_found_s) begin
                    state_d  = ST_OWNED;
                    led_d    = 1'b1;
                    grant_d  = win_oh_s;
                    owner_d  = win_idx_s;
                    last_d   = win_idx_s;
                    hold_d   = '0;
                    denied_d = |(press_s & ~win_oh_s);
                end else begin
                    led_d   = 1'b0;
                    grant_d = '0;
                end
            end
            ST_OWNED: begin
                hold_d   = hold_q + HW'(1);
                // The owner cannot produce a press while owning, so any
                // press here belongs to a contender.
                denied_d = |(press_s & ~grant_q);
                if (!deb_q[owner_q]) begin
                    state_d = ST_GUARD;
                    led_d   = 1'b0;
                    grant_d = '0;
                    guard_d = '0;
                end else if (HOLD_EN && (hold_q == HOLD_LAST)) begin
                    state_d   = ST_GUARD;
                    led_d     = 1'b0;
                    grant_d   = '0;
                    guard_d   = '0;
                    timeout_d = 1'b1;
                end else begin
                    led_d   = 1'b1;
                    grant_d = grant_q;
                end
            end
            ST_GUARD: begin
                led_d    = 1'b0;
                grant_d  = '0;
                denied_d = |press_s;
                if (guard_q == GUARD_LAST) begin
                    state_d = ST_IDLE;
                    guard_d = '0;
                end else begin
                    guard_d = guard_q + GW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                led_d   = 1'b0;
                grant_d = '0;
                hold_d  = '0;
                guard_d = '0;
            end
        endcase
    end

    // Arbitration state and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            led_q     <= 1'b0;
            grant_q   <= '0;
            owner_q   <= '0;
            last_q    <= LAST_INIT;
            hold_q    <= '0;
            guard_q   <= '0;
            denied_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            led_q     <= led_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            hold_q    <= hold_d;
            guard_q   <= guard_d;
            denied_q  <= denied_d;
            timeout_q <= timeout_d;
        end
    end

    assign led     = led_q;
    assign grant   = grant_q;
    assign owner   = owner_q;
    assign denied  = denied_q;
    assign timeout = timeout_q;

endmodule
